// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect selects,
// FSM states, reset PC default and instruction width.
package if_fetch_unit_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEL_BRANCH = 2'b00,
      SEL_JUMP   = 2'b01,
      SEL_REG    = 2'b10,
      SEL_RSVD   = 2'b11
   } redir_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_HOLD  = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_next_pc_calc.sv
// Redirect target calculation for branch, jump and jump-register,
// all relative to the PC+4 captured with the current instruction.
module next_pc_calc
   import if_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  redir_sel_e  sel,
   input  logic [15:0] imm16,
   input  logic [25:0] idx26,
   input  logic [31:0] redir_reg,
   output logic [31:0] target,
   output logic        misalign
);

   logic [31:0] branch_off;

   // Word offset: sign-extend then scale by 4; the add wraps at 32 bits.
   assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

   // NOTE: every output of a combinational block gets a default first so
   // no path through the case can leave it unassigned and infer a latch.
   always_comb begin
      target   = pc_plus4;
      misalign = 1'b0;
      case (sel)
         SEL_BRANCH: target = pc_plus4 + branch_off;
         SEL_JUMP:   target = {pc_plus4[31:28], idx26, 2'b00};
         SEL_REG: begin
            target   = {redir_reg[31:2], 2'b00};
            misalign = |redir_reg[1:0];
         end
         default:    target = pc_plus4;
      endcase
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns PC, runs the imem request/ready handshake,
// latches IR with PC+4 and applies branch/jump/register redirects.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   input  logic               ir_ack,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   input  logic               redir_valid,
   input  logic [1:0]         redir_sel,
   input  logic [15:0]        redir_imm16,
   input  logic [25:0]        redir_idx26,
   input  logic [31:0]        redir_reg,
   output logic               misalign
);

   fetch_state_e state, state_nxt;
   redir_sel_e   sel;
   logic [31:0]  target;
   logic         calc_misalign;
   logic         redir_take;
   logic         discard;
   logic [31:0]  pc_inc;
   logic         pend_valid;
   logic [31:0]  pend_target;

   assign sel        = redir_sel_e'(redir_sel);
   assign redir_take = redir_valid && (sel != SEL_RSVD);
   // A redirect arriving on the completing cycle counts as pending too.
   assign discard    = pend_valid || redir_take;
   assign pc_inc     = pc + 32'd4;

   next_pc_calc u_next_pc_calc (
      .pc_plus4  (pc_plus4),
      .sel       (sel),
      .imm16     (redir_imm16),
      .idx26     (redir_idx26),
      .redir_reg (redir_reg),
      .target    (target),
      .misalign  (calc_misalign)
   );

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (fetch_en)   state_nxt = ST_FETCH;
         ST_FETCH: if (imem_ready) state_nxt = discard ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (ir_ack)     state_nxt = fetch_en ? ST_FETCH : ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req = (state == ST_FETCH);
      ir_valid = (state == ST_HOLD);
   end

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         ir          <= '0;
         pc_plus4    <= '0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         misalign    <= 1'b0;
      end else begin
         misalign <= redir_valid && calc_misalign;
         if (state == ST_FETCH) begin
            // The bus request always runs to completion; redirects wait here.
            if (imem_ready) begin
               if (discard) begin
                  pc         <= redir_take ? target : pend_target;
                  pend_valid <= 1'b0;
               end else begin
                  pc       <= pc_inc;
                  pc_plus4 <= pc_inc;
                  ir       <= imem_rdata;
               end
            end else if (redir_take) begin
               pend_valid  <= 1'b1;
               pend_target <= target;
            end
         end else if (redir_take) begin
            pc <= target;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ack;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redir_valid;
   logic [1:0]  redir_sel;
   logic [15:0] redir_imm16;
   logic [25:0] redir_idx26;
   logic [31:0] redir_reg;
   logic        misalign;

   int n_chk  = 0;
   int n_fail = 0;

   if_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .ir_ack      (ir_ack),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .redir_valid (redir_valid),
      .redir_sel   (redir_sel),
      .redir_imm16 (redir_imm16),
      .redir_idx26 (redir_idx26),
      .redir_reg   (redir_reg),
      .misalign    (misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Completes a fetch already in FETCH: waits, then ready with word.
   task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
      for (int i = 0; i < waits; i++) begin
         n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b exp 1", imem_req); end
         n_chk++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL wait_addr: got %h exp %h", imem_addr, exp_addr); end
         n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL wait_ir_valid: got %b exp 0", ir_valid); end
         @(negedge clk);
      end
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL req: got %b exp 1", imem_req); end
      n_chk++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL addr: got %h exp %h", imem_addr, exp_addr); end
      imem_ready = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ready = 1'b0;
      n_chk++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL ir_valid: got %b exp 1", ir_valid); end
      n_chk++; if (ir !== word) begin n_fail++; $display("FAIL ir: got %h exp %h", ir, word); end
      n_chk++; if (pc !== exp_addr + 32'd4) begin n_fail++; $display("FAIL pc: got %h exp %h", pc, exp_addr + 32'd4); end
      n_chk++; if (pc_plus4 !== exp_addr + 32'd4) begin n_fail++; $display("FAIL pc_plus4: got %h exp %h", pc_plus4, exp_addr + 32'd4); end
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b exp 0", imem_req); end
   endtask

   task automatic ack_fetch();
      ir_ack   = 1'b1;
      fetch_en = 1'b1;
      @(negedge clk);
      ir_ack   = 1'b0;
      fetch_en = 1'b0;
   endtask

   task automatic redirect(input logic [1:0] s, input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] r);
      redir_valid = 1'b1;
      redir_sel   = s;
      redir_imm16 = imm;
      redir_idx26 = idx;
      redir_reg   = r;
      @(negedge clk);
      redir_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", pc); end
      n_chk++; if (ir !== 32'h0) begin n_fail++; $display("FAIL rst_ir: got %h exp 0", ir); end
      n_chk++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc_plus4: got %h exp 0", pc_plus4); end
      n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid: got %b exp 0", ir_valid); end
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
   endtask

   task automatic test_first_fetch();
      rst_n    = 1'b1;
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      fetch_one(32'h0, 32'h2008_0005, 2);
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b exp 1", ir_valid); end
         n_chk++; if (ir !== 32'h2008_0005) begin n_fail++; $display("FAIL hold_ir: got %h exp 20080005", ir); end
         n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_noreq: got %b exp 0", imem_req); end
      end
      ack_fetch();
      fetch_one(32'h4, 32'h0000_0001, 0);
      ack_fetch();
      fetch_one(32'h8, 32'h0000_0002, 1);
      ack_fetch();
      fetch_one(32'hC, 32'h0000_0003, 0);
   endtask

   task automatic test_branch();
      redirect(2'b00, 16'hFFFC, 26'h0, 32'h0);
      n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL br_back_pc: got %h exp 0", pc); end
      n_chk++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL br_ir_valid: got %b exp 1", ir_valid); end
      n_chk++; if (ir !== 32'h3) begin n_fail++; $display("FAIL br_ir: got %h exp 3", ir); end
      redirect(2'b00, 16'h0003, 26'h0, 32'h0);
      n_chk++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL br_fwd_pc: got %h exp 1c", pc); end
   endtask

   task automatic test_jump_reg();
      redirect(2'b10, 16'h0, 26'h0, 32'h4000_0004);
      n_chk++; if (pc !== 32'h4000_0004) begin n_fail++; $display("FAIL jr_setup_pc: got %h exp 40000004", pc); end
      n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL jr_aligned: got %b exp 0", misalign); end
      ack_fetch();
      fetch_one(32'h4000_0004, 32'h1111_2222, 0);
      redirect(2'b01, 16'h0, 26'h0000_100, 32'h0);
      n_chk++; if (pc !== 32'h4000_0400) begin n_fail++; $display("FAIL jump_pc: got %h exp 40000400", pc); end
      redirect(2'b10, 16'h0, 26'h0, 32'h0000_0123);
      n_chk++; if (pc !== 32'h0000_0120) begin n_fail++; $display("FAIL jr_pc: got %h exp 120", pc); end
      n_chk++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_hi: got %b exp 1", misalign); end
      @(negedge clk);
      n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_lo: got %b exp 0", misalign); end
      redirect(2'b11, 16'h0010, 26'h3FF, 32'h0000_0800);
      n_chk++; if (pc !== 32'h0000_0120) begin n_fail++; $display("FAIL rsvd_pc: got %h exp 120", pc); end
   endtask

   task automatic test_redirect_in_fetch();
      ack_fetch();
      n_chk++; if (imem_addr !== 32'h120) begin n_fail++; $display("FAIL rf_addr0: got %h exp 120", imem_addr); end
      redir_valid = 1'b1;
      redir_sel   = 2'b01;
      redir_idx26 = 26'h0000_200;
      @(negedge clk);
      redir_idx26 = 26'h0000_300;
      n_chk++; if (imem_addr !== 32'h120) begin n_fail++; $display("FAIL rf_addr1: got %h exp 120", imem_addr); end
      @(negedge clk);
      redir_valid = 1'b0;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_req: got %b exp 1", imem_req); end
      @(negedge clk);
      n_chk++; if (imem_addr !== 32'h120) begin n_fail++; $display("FAIL rf_addr2: got %h exp 120", imem_addr); end
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ready = 1'b0;
      n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rf_ir_valid: got %b exp 0", ir_valid); end
      n_chk++; if (ir !== 32'h1111_2222) begin n_fail++; $display("FAIL rf_ir: got %h exp 11112222", ir); end
      n_chk++; if (pc !== 32'h4000_0C00) begin n_fail++; $display("FAIL rf_pc: got %h exp 40000c00", pc); end
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_req_drop: got %b exp 0", imem_req); end
      @(negedge clk);
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_idle: got %b exp 0", imem_req); end
   endtask

   task automatic test_reset_mid_fetch();
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b exp 1", imem_req); end
      n_chk++; if (imem_addr !== 32'h4000_0C00) begin n_fail++; $display("FAIL rm_addr: got %h exp 40000c00", imem_addr); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_async: got %b exp 0", imem_req); end
      n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rm_pc: got %h exp 0", pc); end
      n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ir_valid: got %b exp 0", ir_valid); end
      @(negedge clk);
      rst_n    = 1'b1;
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      fetch_one(32'h0, 32'hABCD_0001, 0);
   endtask

   task automatic test_redirect_with_ack();
      ir_ack      = 1'b1;
      fetch_en    = 1'b1;
      redir_valid = 1'b1;
      redir_sel   = 2'b00;
      redir_imm16 = 16'h0001;
      @(negedge clk);
      ir_ack      = 1'b0;
      fetch_en    = 1'b0;
      redir_valid = 1'b0;
      n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ra_ir_valid: got %b exp 0", ir_valid); end
      fetch_one(32'h8, 32'h0000_00AA, 0);
   endtask

   task automatic test_wrap();
      redirect(2'b10, 16'h0, 26'h0, 32'hFFFF_FFFC);
      n_chk++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h exp fffffffc", pc); end
      ack_fetch();
      fetch_one(32'hFFFF_FFFC, 32'h0000_00BB, 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      fetch_en    = 1'b0;
      imem_rdata  = 32'h0;
      imem_ready  = 1'b0;
      ir_ack      = 1'b0;
      redir_valid = 1'b0;
      redir_sel   = 2'b00;
      redir_imm16 = 16'h0;
      redir_idx26 = 26'h0;
      redir_reg   = 32'h0;
      test_reset();
      test_first_fetch();
      test_hold();
      test_branch();
      test_jump_reg();
      test_redirect_in_fetch();
      test_reset_mid_fetch();
      test_redirect_with_ack();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the multicycle MIPS core. Owns the program counter, issues word reads to instruction memory through a request/ready handshake, and latches the returned instruction into IR with PC+4 for the decode/execute stages. Applies branch, jump and jump-register redirects from the control unit. Its PC+4 and branch-target sums feed the shared 32-bit adder path downstream.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  control unit permits a new fetch.
- imem_req  out  1  memory read request.
- imem_addr  out  32  word address (= pc).
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  rdata valid this cycle; completes request.
- ir  out  32  latched instruction.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ack  in  1  consumer takes ir this cycle.
- pc  out  32  current PC.
- pc_plus4  out  32  PC+4 captured with ir.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_sel  in  2  00 branch, 01 jump, 10 register, 11 reserved.
- redir_imm16  in  16  branch offset (words).
- redir_idx26  in  26  jump index.
- redir_reg  in  32  jump-register target.
- misalign  out  1  one-cycle pulse: register target had bits [1:0] != 0.

## Operation
- States: IDLE, FETCH, HOLD. Reset -> IDLE.
- IDLE: fetch_en=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc held stable until imem_ready. On imem_ready: pc <= pc+4; if no pending redirect, ir <= imem_rdata, pc_plus4 <= pc+4, -> HOLD; otherwise discard word, pc <= pending target, clear pending, -> IDLE.
- HOLD: ir_valid=1. On ir_ack: -> FETCH if fetch_en, else IDLE. ir_ack outside HOLD ignored.
- Targets (computed from pc_plus4 register): branch = pc_plus4 + (sign_extend(imm16) << 2), 32-bit wrap; jump = {pc_plus4[31:28], idx26, 2'b00}; register = {redir_reg[31:2], 2'b00}, misalign pulses if redir_reg[1:0] != 0. Sel 11: ignored, no state change.
- Redirect in IDLE or HOLD: pc <= target next edge; in HOLD ir/ir_valid unaffected.
- Redirect in FETCH: target latched into pending register; request runs to completion (no abort on bus). Second redirect while pending overwrites.
- Redirect coincident with ir_ack in HOLD: pc <= target, and the next FETCH uses the new pc.
- PC wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset values: pc=RESET_PC, ir=0, pc_plus4=0, ir_valid=0, imem_req=0, misalign=0, pending cleared, state IDLE.
- imem_req, imem_addr, ir_valid decoded from registered state/pc; no combinational path from any input to any output.
- Min fetch: fetch_en at cycle 0 -> req cycles 1..; ready in cycle k -> ir_valid from k+1.
- Back-to-back with ack+fetch_en: one ready-to-req gap of one cycle (HOLD).
- Reset assertion mid-FETCH drops imem_req immediately (async); memory must tolerate abandoned request.

## Structure
- Shared package: redir_sel encodings, state encoding, RESET_PC default, instruction width constant.
- One sub-module: next_pc_calc (combinational; inputs pc_plus4, sel, imm16, idx26, reg; outputs target, misalign). FSM, pending register and PC/IR registers remain in if_fetch_unit.

## Test plan
- Reset, fetch_en=1, ready after 2 wait cycles with rdata 32'h2008_0005 -> imem_addr=0, ir=32'h2008_0005, pc=4, pc_plus4=4, ir_valid on cycle after ready.
- Hold ir_ack low 5 cycles -> ir_valid stays 1, ir stable, imem_req 0; ack with fetch_en=1 -> next request at addr 4.
- HOLD at pc_plus4=32'h0000_0010, branch imm16=16'hFFFC -> pc=32'h0000_0000; imm16=16'h0003 -> pc=32'h0000_001C.
- Jump with pc_plus4=32'h4000_0008, idx26=26'h0000_100 -> pc=32'h4000_0400; register redir_reg=32'h0000_0123 -> pc=32'h0000_0120, misalign one-cycle pulse.
- Redirect (jump) during FETCH, ready 3 cycles later -> no ir_valid, word discarded, pc=jump target, state IDLE.
- rst_n low during FETCH -> imem_req 0 same cycle, pc=RESET_PC, ir_valid 0; after release, fetch restarts at RESET_PC.
